aes_inv_key_sched: RTL
======================

Name:
aes_inv_key_sched

Overview:
- Sequential AES-128 round-key generator for the decryption datapath.
- Emits round keys in reverse order, round 10 down to round 0, one key per accepted handshake, using the inverse key-expansion recurrence.
- Accepts either the cipher key, in which case it first expands forward 10 cycles to reach the round-10 key, or the round-10 key directly.
- Instantiates S_BOX (port order: output, input) and reuses the codebase's RotWord/SubWord/Rcon conventions.

Parameters:
- None. AES-128 only: Nk=4, Nr=10.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- key_is_last  in  1  sampled with start: 1 = key_in is the round-10 key; 0 = key_in is the cipher key.
- key_in  in  128  key; w0 = key_in[127:96] … w3 = key_in[31:0].
- rk_ready  in  1  consumer accepts rk_out this cycle.
- busy  out  1  high in EXPAND and EMIT.
- rk_valid  out  1  rk_out/rk_round are valid.
- rk_out  out  128  current round key, same word order as key_in.
- rk_round  out  4  round index of rk_out, 10..0.
- done  out  1  one-cycle pulse after round-0 key is accepted.

Behaviour:
- Reset, asynchronous:
  - state = IDLE; key register = 0; round = 0.
  - busy = 0, rk_valid = 0, rk_out = 0, rk_round = 0, done = 0.
  - Reset asserted mid-operation aborts immediately; there is no partial output afterwards.
- g(x, r) = SubWord(RotWord(x)) ^ {Rcon(r), 24'h0}.
  - RotWord: [a,b,c,d] -> [b,c,d,a].
  - Rcon(1..10) = 01,02,04,08,10,20,40,80,1B,36; any other index gives 00.
- Forward step at round r -> r+1, with (w0..w3):
  - w0' = w0 ^ g(w3, r+1)
  - w1' = w1 ^ w0'
  - w2' = w2 ^ w1'
  - w3' = w3 ^ w2'
- Inverse step at round r -> r-1:
  - w3' = w3 ^ w2
  - w2' = w2 ^ w1
  - w1' = w1 ^ w0
  - w0' = w0 ^ g(w3', r)
- All outputs are registered. rk_out is the key register itself; rk_round is the round counter.
- IDLE:
  - On start with key_is_last=1: load key_in, round = 10, go to EMIT.
  - On start with key_is_last=0: load key_in, round = 0, go to EXPAND.
  - Otherwise stay in IDLE.
- EXPAND:
  - Every cycle apply the forward step and increment round.
  - When the register update makes round = 10, go to EMIT. EXPAND lasts exactly 10 cycles.
  - rk_valid = 0; rk_ready is ignored.
- EMIT:
  - rk_valid = 1.
  - On rk_valid & rk_ready with round > 0: apply the inverse step, decrement round, stay in EMIT. One key per cycle under continuous ready.
  - On rk_valid & rk_ready with round = 0: go to IDLE, rk_valid = 0, and pulse done for one cycle in the next cycle.
  - With rk_ready low: rk_out and rk_round hold and rk_valid stays high. Nothing is dropped or skipped.
- Latency, start sampled at edge 0:
  - key_is_last=1: first rk_valid after edge 1.
  - key_is_last=0: first rk_valid after edge 11.
  - Under continuous ready, round 0 is presented 10 cycles after round 10.
- start while busy is ignored. key_in and key_is_last are don't-care outside the start cycle.
- done and start in the same cycle: start is accepted, because state is already IDLE.
- Four S_BOX instances. A single g() datapath is muxed between forward (input w3, Rcon(round+1)) and inverse (input w3^w2, Rcon(round)).

Test Plan:
1. Reset: assert rst asynchronously mid-clock -> all outputs 0 at once. Deassert -> IDLE, busy = 0.
2. Forward-then-reverse with continuous ready:
   - Stimulus: start, key_is_last = 0, key = 2b7e151628aed2a6abf7158809cf4f3c, rk_ready = 1.
   - rk_valid rises after edge 11 with round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
   - Then round 9 = ac7766f319fadc2128d12941575c006e, and later round 1 = a0fafe1788542cb123a339392a6c7605.
   - Round 0 = 2b7e151628aed2a6abf7158809cf4f3c, followed by a done pulse. Exactly 11 handshakes.
3. Direct last key: start, key_is_last = 1, key = d014f9a8c9ee2589e13f0cc8b6630ca6 -> first valid after edge 1; sequence identical to test 2.
4. Backpressure: drop rk_ready for 3 cycles while round 9 is presented -> rk_out holds ac7766f3…, rk_round = 9. On resume, next key is round 8. No key skipped or duplicated.
5. Zero key: start, key_is_last = 0, key = 0 -> rk_round = 1 output = 62636363626363636263636362636363; round 0 = all zero.
6. Protocol corners:
   - start pulsed during EXPAND and EMIT -> ignored, sequence unaffected.
   - rst asserted at round 5 of EMIT -> rk_valid = 0 immediately; a later start runs cleanly.
   - start coincident with done -> new run accepted.

Source files
------------

// File: rtl/aes_inv_key_sched.sv
// AES-128 inverse key schedule: emits round keys 10 down to 0, one per rk_valid/rk_ready handshake.
// Latency: 1 cycle from start with the round-10 key, or 11 cycles from start with the cipher key (10 forward expansion steps).
// Backpressure: with rk_ready low, rk_out and rk_round hold and rk_valid stays high; nothing is dropped or skipped.

module S_BOX (
  output logic [7:0] sbox_o,
  input  logic [7:0] sbox_i
);
  localparam logic [7:0] SBOX_TABLE [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign sbox_o = SBOX_TABLE[sbox_i];
endmodule

module aes_inv_key_sched (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         key_is_last,
  input  logic [127:0] key_in,
  input  logic         rk_ready,
  output logic         busy,
  output logic         rk_valid,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_round,
  output logic         done
);
  typedef enum logic [1:0] {IDLE, EXPAND, EMIT} state_t;

  state_t       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   round_q, round_d;
  logic         busy_q, busy_d;
  logic         valid_q, valid_d;
  logic         done_q, done_d;

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] rc;
    case (idx)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  // Current round-key words, w0 in the top word.
  logic [31:0] w0, w1, w2, w3;
  assign {w0, w1, w2, w3} = key_q;

  // Inverse step: the three upper-index words undo the forward chaining XORs.
  logic [31:0] iw1, iw2, iw3;
  assign iw3 = w3 ^ w2;
  assign iw2 = w2 ^ w1;
  assign iw1 = w1 ^ w0;

  // One shared g() datapath: forward uses w3 and Rcon(round+1), inverse uses the recovered w3 and Rcon(round).
  logic        fwd_sel;
  logic [31:0] g_in, g_rot, g_sub, g_out;
  logic [3:0]  rcon_idx;

  assign fwd_sel  = (state_q == EXPAND);
  assign g_in     = fwd_sel ? w3 : iw3;
  assign rcon_idx = fwd_sel ? (round_q + 4'd1) : round_q;
  assign g_rot    = {g_in[23:0], g_in[31:24]};

  S_BOX u_sbox3 (.sbox_o(g_sub[31:24]), .sbox_i(g_rot[31:24]));
  S_BOX u_sbox2 (.sbox_o(g_sub[23:16]), .sbox_i(g_rot[23:16]));
  S_BOX u_sbox1 (.sbox_o(g_sub[15:8]),  .sbox_i(g_rot[15:8]));
  S_BOX u_sbox0 (.sbox_o(g_sub[7:0]),   .sbox_i(g_rot[7:0]));

  assign g_out = g_sub ^ {rcon(rcon_idx), 24'h0};

  // Candidate next keys for both directions.
  logic [31:0]  f0, f1, f2, f3;
  logic [127:0] fwd_key, inv_key;

  assign f0      = w0 ^ g_out;
  assign f1      = w1 ^ f0;
  assign f2      = w2 ^ f1;
  assign f3      = w3 ^ f2;
  assign fwd_key = {f0, f1, f2, f3};
  assign inv_key = {w0 ^ g_out, iw1, iw2, iw3};

  // Next-state and registered-output decode.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          key_d = key_in;
          if (key_is_last) begin
            round_d = 4'd10;
            state_d = EMIT;
          end else begin
            round_d = 4'd0;
            state_d = EXPAND;
          end
        end
      end
      EXPAND: begin
        key_d   = fwd_key;
        round_d = round_q + 4'd1;
        if (round_q == 4'd9) begin
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (rk_ready) begin
          if (round_q != 4'd0) begin
            key_d   = inv_key;
            round_d = round_q - 4'd1;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d  = (state_d != IDLE);
    valid_d = (state_d == EMIT);
  end

  // State, key, round and output registers; reset aborts any run in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      round_q <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign busy     = busy_q;
  assign rk_valid = valid_q;
  assign rk_out   = key_q;
  assign rk_round = round_q;
  assign done     = done_q;
endmodule
